// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding
// and default timing parameters.
package stopwatch_pkg;

   localparam int unsigned DEFAULT_CLK_HZ          = 50_000_000;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      LAP     = 2'd3
   } sw_state_t;

endpackage

// File: rtl/button_conditioner.sv
// Raw pushbutton -> 2-flop synchronizer -> debouncer -> one-cycle press pulse
// on an accepted rising level only.
module button_conditioner
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset_n,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             level;
   logic [CNT_W-1:0] stable_cnt;

   // A new level is accepted after DEBOUNCE_CYCLES consecutive cycles differing from the old one.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_a     <= 1'b0;
         sync_b     <= 1'b0;
         level      <= 1'b0;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         press  <= 1'b0;
         if (sync_b == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            stable_cnt <= '0;
            level      <= sync_b;
            press      <= sync_b;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control FSM: conditions three buttons, runs the one-second
// prescaler and drives the time counter's clear/hold and the lap freeze.
module stopwatch_control
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ          = DEFAULT_CLK_HZ,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       btn_start_stop,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic       count_clear,
   output logic       hold_count,
   output logic       lap_freeze,
   output logic [1:0] state
);

   localparam int unsigned      PSC_W    = $clog2(CLK_HZ);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_HZ - 1);

   logic             start_stop_press;
   logic             lap_press;
   logic             clear_press;
   sw_state_t        cur_state;
   sw_state_t        next_state;
   logic             clear_taken;
   logic             counting;
   logic [PSC_W-1:0] prescaler;

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_stop (
      .clock(clock), .reset_n(reset_n), .btn_raw(btn_start_stop), .press(start_stop_press)
   );
   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
      .clock(clock), .reset_n(reset_n), .btn_raw(btn_lap), .press(lap_press)
   );
   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clock(clock), .reset_n(reset_n), .btn_raw(btn_clear), .press(clear_press)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) cur_state <= IDLE;
      else          cur_state <= next_state;
   end

   // Clear only acts in PAUSED, so elsewhere it must not mask start_stop.
   always_comb begin
      next_state  = cur_state;
      clear_taken = 1'b0;
      case (cur_state)
         IDLE: begin
            if (start_stop_press) next_state = RUNNING;
         end
         RUNNING: begin
            if (start_stop_press) next_state = PAUSED;
            else if (lap_press)   next_state = LAP;
         end
         LAP: begin
            if (start_stop_press) next_state = PAUSED;
            else if (lap_press)   next_state = RUNNING;
         end
         PAUSED: begin
            if (clear_press) begin
               next_state  = IDLE;
               clear_taken = 1'b1;
            end else if (start_stop_press) begin
               next_state = RUNNING;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign counting = (cur_state == RUNNING) || (cur_state == LAP);

   always_ff @(posedge clock) begin
      if (!reset_n || cur_state == IDLE) begin
         prescaler <= '0;
      end else if (counting) begin
         prescaler <= (prescaler == PSC_LAST) ? '0 : prescaler + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) count_clear <= 1'b1;
      else          count_clear <= clear_taken;
   end

   assign hold_count = !(counting && prescaler == PSC_LAST);
   assign lap_freeze = (cur_state == LAP);
   assign state      = cur_state;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with CLK_HZ=10, DEBOUNCE_CYCLES=4.
module tb_stopwatch_control;
   import stopwatch_pkg::*;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       btn_start_stop;
   logic       btn_lap;
   logic       btn_clear;
   logic       count_clear;
   logic       hold_count;
   logic       lap_freeze;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int lat    = 0;   // raw drive -> state change, in cycles

   stopwatch_control #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset_n(reset_n), .btn_start_stop(btn_start_stop),
      .btn_lap(btn_lap), .btn_clear(btn_clear), .count_clear(count_clear),
      .hold_count(hold_count), .lap_freeze(lap_freeze), .state(state)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(negedge clock);
   endtask

   // mask = {clear, start_stop, lap}; held 12 cycles, 24 cycles total
   task automatic press(input logic [2:0] mask, input logic [1:0] target, output int seen);
      seen = 0;
      btn_clear = mask[2]; btn_start_stop = mask[1]; btn_lap = mask[0];
      for (int n = 1; n <= 24; n++) begin
         tick();
         if (n == 12) begin btn_clear = 0; btn_start_stop = 0; btn_lap = 0; end
         if (seen == 0 && state === target) seen = n;
      end
   endtask

   task automatic test_reset();
      reset_n = 0; btn_start_stop = 0; btn_lap = 0; btn_clear = 0;
      repeat (3) tick();
      checks++; if (state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
      checks++; if (hold_count !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b expected 1", hold_count); end
      checks++; if (lap_freeze !== 1'b0) begin errors++; $display("FAIL rst_lap_freeze: got %b expected 0", lap_freeze); end
      checks++; if (count_clear !== 1'b1) begin errors++; $display("FAIL rst_count_clear: got %b expected 1", count_clear); end
      reset_n = 1; #1;
      checks++; if (count_clear !== 1'b1) begin errors++; $display("FAIL cc_first_cycle: got %b expected 1", count_clear); end
      tick();
      checks++; if (count_clear !== 1'b0) begin errors++; $display("FAIL cc_after_first: got %b expected 0", count_clear); end
   endtask

   task automatic test_start();
      int k;
      btn_start_stop = 1;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (n == 20) btn_start_stop = 0;
         if (lat == 0 && state === RUNNING) lat = n;
         checks++; if (count_clear !== 1'b0) begin errors++; $display("FAIL start_cc n=%0d: got %b expected 0", n, count_clear); end
         if (lat != 0) begin
            k = n - lat;
            checks++;
            if (hold_count !== ((k % 10 == 9) ? 1'b0 : 1'b1)) begin
               errors++; $display("FAIL start_hold k=%0d: got %b expected %b", k, hold_count, (k % 10 != 9));
            end
         end
      end
      checks++; if (lat == 0) begin errors++; $display("FAIL start_timeout: got no RUNNING expected RUNNING"); end
      checks++; if (state !== RUNNING) begin errors++; $display("FAIL start_single_pulse: got %0d expected 1", state); end
   endtask

   task automatic test_lap_bounce();
      int lows = 0, last = -1, s, seen;
      for (int i = 0; i < 60; i++) begin
         btn_lap = (i < 12) ? ((i % 4) < 2) : (i < 45);
         tick();
         s = i + 1;
         checks++;
         if (s < 12 + lat) begin
            if (state !== RUNNING || lap_freeze !== 1'b0) begin
               errors++; $display("FAIL lap_before s=%0d: got state %0d freeze %b expected 1/0", s, state, lap_freeze);
            end
         end else if (state !== LAP || lap_freeze !== 1'b1) begin
            errors++; $display("FAIL lap_after s=%0d: got state %0d freeze %b expected 3/1", s, state, lap_freeze);
         end
         if (hold_count === 1'b0) begin
            lows++;
            if (last >= 0) begin
               checks++;
               if (s - last != 10) begin errors++; $display("FAIL lap_hold_spacing: got %0d expected 10", s - last); end
            end
            last = s;
         end
      end
      checks++; if (lows < 5) begin errors++; $display("FAIL lap_hold_count: got %0d expected >=5", lows); end
      press(3'b001, RUNNING, seen);
      checks++; if (seen != lat) begin errors++; $display("FAIL lap_exit_latency: got %0d expected %0d", seen, lat); end
      checks++; if (state !== RUNNING || lap_freeze !== 1'b0) begin
         errors++; $display("FAIL lap_exit: got state %0d freeze %b expected 1/0", state, lap_freeze);
      end
   endtask

   task automatic test_clear_running();
      btn_clear = 1;
      for (int n = 1; n <= 24; n++) begin
         tick();
         if (n == 12) btn_clear = 0;
         checks++;
         if (state !== RUNNING || count_clear !== 1'b0) begin
            errors++; $display("FAIL clear_running n=%0d: got state %0d cc %b expected 1/0", n, state, count_clear);
         end
      end
   endtask

   task automatic test_pause_resume();
      int found = 0, w, seen, lows = 0, r = 0, k;
      for (int n = 0; n < 12 && found == 0; n++) begin
         tick();
         if (hold_count === 1'b0) found = 1;
      end
      checks++; if (found == 0) begin errors++; $display("FAIL pause_sync: got no hold low expected one"); end
      // Pulse must land on the cycle where the prescaler reads 6.
      w = 8 - lat;
      while (w < 1) w += 10;
      repeat (w) tick();
      press(3'b010, PAUSED, seen);
      checks++; if (state !== PAUSED) begin errors++; $display("FAIL pause_state: got %0d expected 2", state); end
      for (int n = 0; n < 50; n++) begin
         tick();
         if (hold_count !== 1'b1) lows++;
      end
      checks++; if (lows != 0) begin errors++; $display("FAIL pause_hold: got %0d lows expected 0", lows); end
      btn_start_stop = 1;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (n == 12) btn_start_stop = 0;
         if (r == 0) begin
            if (state === RUNNING) r = n;
         end else begin
            k = n - r;
            checks++;
            if (hold_count !== ((k % 10 == 2) ? 1'b0 : 1'b1)) begin
               errors++; $display("FAIL resume_hold k=%0d: got %b expected %b", k, hold_count, (k % 10 != 2));
            end
         end
      end
      checks++; if (r == 0) begin errors++; $display("FAIL resume_timeout: got no RUNNING expected RUNNING"); end
   endtask

   task automatic test_clear_paused();
      int seen, cc = 0, idle_at = 0, cc_at = 0;
      press(3'b010, PAUSED, seen);
      checks++; if (state !== PAUSED) begin errors++; $display("FAIL clr_pause_state: got %0d expected 2", state); end
      btn_clear = 1;
      for (int n = 1; n <= 24; n++) begin
         tick();
         if (n == 12) btn_clear = 0;
         if (idle_at == 0 && state === IDLE) idle_at = n;
         if (count_clear === 1'b1) begin cc++; cc_at = n; end
      end
      checks++; if (state !== IDLE) begin errors++; $display("FAIL clr_state: got %0d expected 0", state); end
      checks++; if (cc != 1) begin errors++; $display("FAIL clr_cc_pulses: got %0d expected 1", cc); end
      checks++; if (cc_at != idle_at) begin errors++; $display("FAIL clr_cc_timing: got %0d expected %0d", cc_at, idle_at); end
   endtask

   task automatic test_back_to_back();
      int seen, cc = 0, ran = 0;
      press(3'b010, RUNNING, seen);
      press(3'b010, PAUSED, seen);
      checks++; if (state !== PAUSED) begin errors++; $display("FAIL b2b_setup: got %0d expected 2", state); end
      btn_start_stop = 1; btn_clear = 1;
      for (int n = 1; n <= 24; n++) begin
         tick();
         if (n == 12) begin btn_start_stop = 0; btn_clear = 0; end
         if (state === RUNNING) ran++;
         if (count_clear === 1'b1) cc++;
      end
      checks++; if (state !== IDLE) begin errors++; $display("FAIL b2b_state: got %0d expected 0", state); end
      checks++; if (ran != 0) begin errors++; $display("FAIL b2b_running: got %0d cycles expected 0", ran); end
      checks++; if (cc != 1) begin errors++; $display("FAIL b2b_cc_pulses: got %0d expected 1", cc); end
   endtask

   task automatic test_reset_mid();
      int seen, found = 0, left = 0;
      press(3'b010, RUNNING, seen);
      press(3'b001, LAP, seen);
      checks++; if (state !== LAP) begin errors++; $display("FAIL rmid_setup: got %0d expected 3", state); end
      for (int n = 0; n < 12 && found == 0; n++) begin
         tick();
         if (hold_count === 1'b0) found = 1;
      end
      checks++; if (found == 0) begin errors++; $display("FAIL rmid_sync: got no hold low expected one"); end
      repeat (5) tick();
      btn_start_stop = 1;
      repeat (3) tick();
      checks++; if (dut.prescaler !== 4'd7) begin errors++; $display("FAIL rmid_prescaler_pre: got %0d expected 7", dut.prescaler); end
      reset_n = 0;
      tick();
      checks++; if (state !== IDLE) begin errors++; $display("FAIL rmid_state: got %0d expected 0", state); end
      checks++; if (lap_freeze !== 1'b0) begin errors++; $display("FAIL rmid_freeze: got %b expected 0", lap_freeze); end
      checks++; if (hold_count !== 1'b1) begin errors++; $display("FAIL rmid_hold: got %b expected 1", hold_count); end
      checks++; if (dut.prescaler !== 4'd0) begin errors++; $display("FAIL rmid_prescaler: got %0d expected 0", dut.prescaler); end
      checks++; if (count_clear !== 1'b1) begin errors++; $display("FAIL rmid_cc: got %b expected 1", count_clear); end
      reset_n = 1; btn_start_stop = 0;
      for (int n = 0; n < 15; n++) begin
         tick();
         if (state !== IDLE) left++;
      end
      checks++; if (left != 0) begin errors++; $display("FAIL rmid_pending_press: got %0d non-idle cycles expected 0", left); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_lap_bounce();
      test_clear_running();
      test_pause_resume();
      test_clear_paused();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
